atm_banking: RTL and testbench

Synchronous ATM session controller with a built-in four-account store. It sequences card insertion, language select, PIN check, one transaction (balance, withdraw, deposit, transfer, PIN change), receipt, and repeat/exit. It reports each completed action with a one-cycle status pulse and sits between front-panel/cash-handler inputs and the display/printer logic.

---
 rtl/atm_pkg.sv | 67 ++++++
 rtl/atm_account_store.sv | 69 ++++++
 rtl/atm_banking.sv | 189 ++++++++++++++++++
 tb/tb_atm_banking.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : atm_pkg                                                       |
// | Purpose  : Shared widths, state encoding, opcodes and store reset data   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package atm_pkg;

    localparam int ACCT_W   = 17;
    localparam int PIN_W    = 17;
    localparam int AMT_W    = 19;
    localparam int NUM_ACCT = 4;
    localparam int IDX_W    = 2;

    localparam logic [AMT_W-1:0] RESET_BAL = 19'd10000;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LANG     = 4'd1,
        ST_PIN      = 4'd2,
        ST_MENU     = 4'd3,
        ST_BALANCE  = 4'd4,
        ST_WITHDRAW = 4'd5,
        ST_DEPOSIT  = 4'd6,
        ST_TRANSFER = 4'd7,
        ST_CHGPIN   = 4'd8,
        ST_RECEIPT  = 4'd9,
        ST_ANOTHER  = 4'd10,
        ST_EXIT     = 4'd11
    } state_t;

    localparam logic [2:0] OP_BALANCE  = 3'b001;
    localparam logic [2:0] OP_WITHDRAW = 3'b010;
    localparam logic [2:0] OP_DEPOSIT  = 3'b011;
    localparam logic [2:0] OP_TRANSFER = 3'b100;
    localparam logic [2:0] OP_CHGPIN   = 3'b101;

    // Bit positions inside the registered status-pulse vector
    localparam int P_RECEIPT  = 0;
    localparam int P_PIN      = 1;
    localparam int P_WITHDRAW = 2;
    localparam int P_DEPOSIT  = 3;
    localparam int P_BALANCE  = 4;
    localparam int P_FINISHED = 5;
    localparam int P_TRANSFER = 6;
    localparam int NUM_PULSE  = 7;

    function automatic logic [ACCT_W-1:0] acct_no(input logic [IDX_W-1:0] idx);
        case (idx)
            2'd0:    acct_no = 17'h01111;
            2'd1:    acct_no = 17'h02222;
            2'd2:    acct_no = 17'h03333;
            default: acct_no = 17'h04444;
        endcase
    endfunction

    function automatic logic [PIN_W-1:0] reset_pin(input logic [IDX_W-1:0] idx);
        case (idx)
            2'd0:    reset_pin = 17'h00123;
            2'd1:    reset_pin = 17'h00456;
            2'd2:    reset_pin = 17'h00789;
            default: reset_pin = 17'h00321;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/atm_account_store.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : atm_account_store                                             |
// | Purpose  : Four-entry account file with own/destination lookup ports    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module atm_account_store
    import atm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ACCT_W-1:0] i_own_acct,
    input  logic [ACCT_W-1:0] i_dst_acct,
    input  logic [IDX_W-1:0]  i_sel_idx,
    output logic              o_own_hit,
    output logic [IDX_W-1:0]  o_own_idx,
    output logic [PIN_W-1:0]  o_own_pin,
    output logic              o_dst_hit,
    output logic [IDX_W-1:0]  o_dst_idx,
    output logic [AMT_W-1:0]  o_dst_bal,
    output logic [AMT_W-1:0]  o_sel_bal,
    input  logic              i_sel_bal_we,
    input  logic [AMT_W-1:0]  i_sel_bal,
    input  logic              i_dst_bal_we,
    input  logic [AMT_W-1:0]  i_dst_bal,
    input  logic              i_pin_we,
    input  logic [PIN_W-1:0]  i_pin
);

    logic [PIN_W-1:0] r_pin [NUM_ACCT];
    logic [AMT_W-1:0] r_bal [NUM_ACCT];

    // Account numbers are fixed, so matching is against constants only
    always_comb begin
        o_own_hit = 1'b0;
        o_own_idx = '0;
        o_dst_hit = 1'b0;
        o_dst_idx = '0;
        for (int i = NUM_ACCT - 1; i >= 0; i--) begin
            if (i_own_acct == acct_no(IDX_W'(i))) begin
                o_own_hit = 1'b1;
                o_own_idx = IDX_W'(i);
            end
            if (i_dst_acct == acct_no(IDX_W'(i))) begin
                o_dst_hit = 1'b1;
                o_dst_idx = IDX_W'(i);
            end
        end
    end

    assign o_own_pin = r_pin[o_own_idx];
    assign o_dst_bal = r_bal[o_dst_idx];
    assign o_sel_bal = r_bal[i_sel_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACCT; i++) begin
                r_pin[i] <= reset_pin(IDX_W'(i));
                r_bal[i] <= RESET_BAL;
            end
        end else begin
            if (i_pin_we)     r_pin[i_sel_idx] <= i_pin;
            if (i_sel_bal_we) r_bal[i_sel_idx] <= i_sel_bal;
            if (i_dst_bal_we) r_bal[o_dst_idx] <= i_dst_bal;
        end
    end

endmodule
`default_nettype wire

// File: rtl/atm_banking.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : atm_banking                                                   |
// | Purpose  : ATM session sequencer driving the account store and pulses   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module atm_banking
    import atm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              Card_in,
    input  logic              Language,
    input  logic              Timer,
    input  logic              money_counting,
    input  logic              another_transaction_bit,
    input  logic [2:0]        opcode,
    input  logic [PIN_W-1:0]  password,
    input  logic [PIN_W-1:0]  new_pin,
    input  logic              allowwithdraw,
    input  logic              take_receipt,
    input  logic              allow_transfer,
    input  logic [ACCT_W-1:0] Pers_Account_No,
    input  logic [ACCT_W-1:0] ur_account,
    input  logic [AMT_W-1:0]  withdraw_amount,
    input  logic [AMT_W-1:0]  Transfer_Amount,
    input  logic [AMT_W-1:0]  deposit_amount,
    output logic              Transfer_Successfully,
    output logic              ATM_Usage_Finished,
    output logic              Balance_Shown,
    output logic              Deposited_Successfully,
    output logic              Withdrew_Successfully,
    output logic              Pin_Changed_Successfully,
    output logic              Receipt_Printed
);

    state_t                 r_state, w_next;
    logic [1:0]             r_fail, w_fail_next;
    logic                   r_lang;
    logic [IDX_W-1:0]       r_own_idx;
    logic [NUM_PULSE-1:0]   r_pulse, w_pulse;

    logic                   w_own_hit, w_dst_hit;
    logic [IDX_W-1:0]       w_own_idx, w_dst_idx;
    logic [PIN_W-1:0]       w_own_pin;
    logic [AMT_W-1:0]       w_dst_bal, w_sel_bal;
    logic                   w_sel_we, w_dst_we, w_pin_we;
    logic [AMT_W-1:0]       w_sel_wdata;
    logic [AMT_W:0]         w_dep_sum, w_xfer_sum;

    atm_account_store u_store (
        .clk          (clk),
        .rst          (reset),
        .i_own_acct   (Pers_Account_No),
        .i_dst_acct   (ur_account),
        .i_sel_idx    (r_own_idx),
        .o_own_hit    (w_own_hit),
        .o_own_idx    (w_own_idx),
        .o_own_pin    (w_own_pin),
        .o_dst_hit    (w_dst_hit),
        .o_dst_idx    (w_dst_idx),
        .o_dst_bal    (w_dst_bal),
        .o_sel_bal    (w_sel_bal),
        .i_sel_bal_we (w_sel_we),
        .i_sel_bal    (w_sel_wdata),
        .i_dst_bal_we (w_dst_we),
        .i_dst_bal    (w_xfer_sum[AMT_W-1:0]),
        .i_pin_we     (w_pin_we),
        .i_pin        (new_pin)
    );

    // One extra bit catches 19-bit overflow on credits
    assign w_dep_sum  = {1'b0, w_sel_bal} + {1'b0, deposit_amount};
    assign w_xfer_sum = {1'b0, w_dst_bal} + {1'b0, Transfer_Amount};

    always_comb begin
        w_next      = r_state;
        w_fail_next = r_fail;
        w_pulse     = '0;
        w_sel_we    = 1'b0;
        w_sel_wdata = w_sel_bal;
        w_dst_we    = 1'b0;
        w_pin_we    = 1'b0;
        if (r_state != ST_IDLE && (!Card_in || Timer)) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (Card_in) w_next = ST_LANG;
                ST_LANG:  w_next = ST_PIN;
                ST_PIN: begin
                    if (w_own_hit && password == w_own_pin) begin
                        w_next      = ST_MENU;
                        w_fail_next = 2'd0;
                    end else if (r_fail == 2'd2) begin
                        w_next      = ST_IDLE;
                        w_fail_next = 2'd0;
                    end else begin
                        w_fail_next = r_fail + 2'd1;
                    end
                end
                ST_MENU: begin
                    case (opcode)
                        OP_BALANCE:  w_next = ST_BALANCE;
                        OP_WITHDRAW: w_next = ST_WITHDRAW;
                        OP_DEPOSIT:  w_next = ST_DEPOSIT;
                        OP_TRANSFER: w_next = ST_TRANSFER;
                        OP_CHGPIN:   w_next = ST_CHGPIN;
                        default:     w_next = ST_MENU;
                    endcase
                end
                ST_BALANCE: begin
                    w_pulse[P_BALANCE] = 1'b1;
                    w_next             = ST_RECEIPT;
                end
                ST_WITHDRAW: begin
                    if (allowwithdraw && withdraw_amount <= w_sel_bal) begin
                        w_sel_we            = 1'b1;
                        w_sel_wdata         = w_sel_bal - withdraw_amount;
                        w_pulse[P_WITHDRAW] = 1'b1;
                    end
                    w_next = ST_RECEIPT;
                end
                ST_DEPOSIT: begin
                    if (money_counting) begin
                        if (!w_dep_sum[AMT_W]) begin
                            w_sel_we           = 1'b1;
                            w_sel_wdata        = w_dep_sum[AMT_W-1:0];
                            w_pulse[P_DEPOSIT] = 1'b1;
                        end
                        w_next = ST_RECEIPT;
                    end
                end
                ST_TRANSFER: begin
                    if (allow_transfer && w_dst_hit && w_dst_idx != r_own_idx &&
                        Transfer_Amount <= w_sel_bal && !w_xfer_sum[AMT_W]) begin
                        w_sel_we            = 1'b1;
                        w_sel_wdata         = w_sel_bal - Transfer_Amount;
                        w_dst_we            = 1'b1;
                        w_pulse[P_TRANSFER] = 1'b1;
                    end
                    w_next = ST_RECEIPT;
                end
                ST_CHGPIN: begin
                    w_pin_we       = 1'b1;
                    w_pulse[P_PIN] = 1'b1;
                    w_next         = ST_RECEIPT;
                end
                ST_RECEIPT: begin
                    w_pulse[P_RECEIPT] = take_receipt;
                    w_next             = ST_ANOTHER;
                end
                ST_ANOTHER: w_next = another_transaction_bit ? ST_MENU : ST_EXIT;
                ST_EXIT: begin
                    w_pulse[P_FINISHED] = 1'b1;
                    w_next              = ST_IDLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_fail    <= 2'd0;
            r_lang    <= 1'b0;
            r_own_idx <= '0;
            r_pulse   <= '0;
        end else begin
            r_state <= w_next;
            r_fail  <= w_fail_next;
            r_pulse <= w_pulse;
            if (r_state == ST_LANG && w_next == ST_PIN)
                r_lang <= Language;
            if (r_state == ST_PIN && w_next == ST_MENU)
                r_own_idx <= w_own_idx;
        end
    end

    assign Transfer_Successfully    = r_pulse[P_TRANSFER];
    assign ATM_Usage_Finished       = r_pulse[P_FINISHED];
    assign Balance_Shown            = r_pulse[P_BALANCE];
    assign Deposited_Successfully   = r_pulse[P_DEPOSIT];
    assign Withdrew_Successfully    = r_pulse[P_WITHDRAW];
    assign Pin_Changed_Successfully = r_pulse[P_PIN];
    assign Receipt_Printed          = r_pulse[P_RECEIPT];

endmodule
`default_nettype wire

// File: tb/tb_atm_banking.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_atm_banking                                                |
// | Purpose  : Directed session bench with a transaction-level account model|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_atm_banking;
    import atm_pkg::*;

    logic        clk = 1'b0;
    logic        reset, Card_in, Language, Timer, money_counting, another_transaction_bit;
    logic [2:0]  opcode;
    logic [16:0] password, new_pin, Pers_Account_No, ur_account;
    logic        allowwithdraw, take_receipt, allow_transfer;
    logic [18:0] withdraw_amount, Transfer_Amount, deposit_amount;
    logic        Transfer_Successfully, ATM_Usage_Finished, Balance_Shown, Deposited_Successfully;
    logic        Withdrew_Successfully, Pin_Changed_Successfully, Receipt_Printed;

    // Expected-pulse encoding: {xfer, finished, balance, deposit, withdraw, pin, receipt}
    localparam logic [6:0] E_NONE = 7'b0000000;
    localparam logic [6:0] E_RCPT = 7'b0000001;
    localparam logic [6:0] E_PIN  = 7'b0000010;
    localparam logic [6:0] E_WD   = 7'b0000100;
    localparam logic [6:0] E_DEP  = 7'b0001000;
    localparam logic [6:0] E_BAL  = 7'b0010000;
    localparam logic [6:0] E_FIN  = 7'b0100000;
    localparam logic [6:0] E_XFER = 7'b1000000;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit rnd_mode = 1'b0;
    logic [6:0] exp_q[$];
    logic [6:0] act, e;

    // Account model
    logic [16:0] m_acct [4];
    logic [16:0] m_pin  [4];
    int          m_bal  [4];
    int          m_fail, m_own;

    atm_banking dut (
        .clk(clk), .reset(reset), .Card_in(Card_in), .Language(Language), .Timer(Timer),
        .money_counting(money_counting), .another_transaction_bit(another_transaction_bit),
        .opcode(opcode), .password(password), .new_pin(new_pin), .allowwithdraw(allowwithdraw),
        .take_receipt(take_receipt), .allow_transfer(allow_transfer),
        .Pers_Account_No(Pers_Account_No), .ur_account(ur_account),
        .withdraw_amount(withdraw_amount), .Transfer_Amount(Transfer_Amount),
        .deposit_amount(deposit_amount),
        .Transfer_Successfully(Transfer_Successfully), .ATM_Usage_Finished(ATM_Usage_Finished),
        .Balance_Shown(Balance_Shown), .Deposited_Successfully(Deposited_Successfully),
        .Withdrew_Successfully(Withdrew_Successfully),
        .Pin_Changed_Successfully(Pin_Changed_Successfully), .Receipt_Printed(Receipt_Printed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        act = {Transfer_Successfully, ATM_Usage_Finished, Balance_Shown, Deposited_Successfully,
               Withdrew_Successfully, Pin_Changed_Successfully, Receipt_Printed};
        if (rnd_mode) begin
            checks++;
            if ($isunknown(act) || $countones(act & 7'b1011110) > 1) begin
                failures++;
                $display("FAIL random_pulses cyc=%0d actual=%b required=no X, <=1 txn pulse", cyc, act);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL pulses cyc=%0d actual=%b required=%b", cyc, act, e);
            end
        end
    end

    task automatic model_reset();
        m_acct = '{17'h01111, 17'h02222, 17'h03333, 17'h04444};
        m_pin  = '{17'h00123, 17'h00456, 17'h00789, 17'h00321};
        m_bal  = '{10000, 10000, 10000, 10000};
        m_fail = 0;
        m_own  = 0;
    endtask

    function automatic int find(input logic [16:0] a);
        find = -1;
        for (int i = 0; i < 4; i++) if (m_acct[i] == a) find = i;
    endfunction

    task automatic step(input logic [6:0] ex);
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string name, input state_t req);
        checks++;
        if (dut.r_state !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, dut.r_state, req);
        end
    endtask

    task automatic chk_bal(input int idx, input int lit);
        checks++;
        if (int'(dut.u_store.r_bal[idx]) != lit || m_bal[idx] != lit) begin
            failures++;
            $display("FAIL balance%0d actual=%0d model=%0d required=%0d",
                     idx, dut.u_store.r_bal[idx], m_bal[idx], lit);
        end
    endtask

    task automatic chk_store();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (int'(dut.u_store.r_bal[i]) != m_bal[i]) begin
                failures++;
                $display("FAIL store_bal%0d actual=%0d required=%0d", i, dut.u_store.r_bal[i], m_bal[i]);
            end
        end
    endtask

    task automatic start_session(input logic [16:0] a, input logic [16:0] p);
        Card_in = 1'b1; Pers_Account_No = a; password = p;
        step(E_NONE);   // IDLE -> LANG
        step(E_NONE);   // LANG -> PIN
    endtask

    task automatic pin_try(input logic [16:0] p);
        int i;
        password = p;
        i = find(Pers_Account_No);
        if (i >= 0 && m_pin[i] == p) begin
            m_own = i; m_fail = 0;
        end else begin
            m_fail++;
            if (m_fail == 3) m_fail = 0;
        end
        step(E_NONE);
    endtask

    task automatic do_balance();
        opcode = 3'b001;
        step(E_NONE);
        step(E_BAL);
    endtask

    task automatic do_withdraw(input int amt, input logic allow);
        bit ok;
        opcode = 3'b010; withdraw_amount = 19'(amt); allowwithdraw = allow;
        step(E_NONE);
        ok = allow && amt <= m_bal[m_own];
        if (ok) m_bal[m_own] -= amt;
        step(ok ? E_WD : E_NONE);
    endtask

    task automatic do_deposit(input int amt);
        bit ok;
        opcode = 3'b011; deposit_amount = 19'(amt); money_counting = 1'b1;
        step(E_NONE);
        ok = (m_bal[m_own] + amt) < 524288;
        if (ok) m_bal[m_own] += amt;
        step(ok ? E_DEP : E_NONE);
    endtask

    task automatic do_transfer(input logic [16:0] dst, input int amt, input logic allow);
        bit ok;
        int d;
        opcode = 3'b100; ur_account = dst; Transfer_Amount = 19'(amt); allow_transfer = allow;
        step(E_NONE);
        d = find(dst);
        ok = allow && d >= 0 && d != m_own && amt <= m_bal[m_own] && (m_bal[d] + amt) < 524288;
        if (ok) begin
            m_bal[m_own] -= amt;
            m_bal[d]     += amt;
        end
        step(ok ? E_XFER : E_NONE);
    endtask

    task automatic do_chgpin(input logic [16:0] np);
        opcode = 3'b101; new_pin = np;
        step(E_NONE);
        m_pin[m_own] = np;
        step(E_PIN);
    endtask

    task automatic finish_txn(input logic take, input logic again);
        take_receipt = take;
        step(take ? E_RCPT : E_NONE);
        another_transaction_bit = again;
        step(E_NONE);
        if (!again) begin
            step(E_FIN);
            Card_in = 1'b0;
            step(E_NONE);
        end
    endtask

    initial begin
        reset = 1'b1; Card_in = 1'b0; Language = 1'b0; Timer = 1'b0; money_counting = 1'b0;
        another_transaction_bit = 1'b0; opcode = 3'b000; password = '0; new_pin = '0;
        allowwithdraw = 1'b0; take_receipt = 1'b0; allow_transfer = 1'b0;
        Pers_Account_No = '0; ur_account = '0;
        withdraw_amount = '0; Transfer_Amount = '0; deposit_amount = '0;
        model_reset();

        step(E_NONE);
        step(E_NONE);
        chk_state("reset_state", ST_IDLE);
        reset = 1'b0;
        step(E_NONE);
        step(E_NONE);
        chk_state("idle_no_card", ST_IDLE);

        // Balance check: 8 edges IDLE..EXIT
        Language = 1'b1;
        start_session(17'h01111, 17'h00123);
        pin_try(17'h00123);
        chk_state("pin_ok_menu", ST_MENU);
        do_balance();
        finish_txn(1'b1, 1'b0);
        chk_state("after_exit_idle", ST_IDLE);

        // Withdrawals on account 0
        start_session(17'h01111, 17'h00123);
        pin_try(17'h00123);
        do_withdraw(2500, 1'b1);
        finish_txn(1'b1, 1'b1);
        do_balance();
        finish_txn(1'b0, 1'b1);
        do_withdraw(8000, 1'b1);
        finish_txn(1'b0, 1'b1);
        do_withdraw(0, 1'b1);
        finish_txn(1'b0, 1'b1);
        do_withdraw(100, 1'b0);
        finish_txn(1'b1, 1'b0);
        chk_bal(0, 7500);

        // Transfers from account 1
        start_session(17'h02222, 17'h00456);
        pin_try(17'h00456);
        do_transfer(17'h03333, 3000, 1'b1);
        finish_txn(1'b0, 1'b1);
        do_transfer(17'h02222, 100, 1'b1);
        finish_txn(1'b0, 1'b1);
        do_transfer(17'h05555, 100, 1'b1);
        finish_txn(1'b0, 1'b1);
        do_transfer(17'h01111, 7001, 1'b1);
        finish_txn(1'b0, 1'b0);
        chk_bal(1, 7000);
        chk_bal(2, 13000);

        // Three consecutive wrong PINs lock the session out
        start_session(17'h04444, 17'h00000);
        pin_try(17'h00000);
        pin_try(17'h00001);
        chk_state("pin_fail2_stays", ST_PIN);
        pin_try(17'h00002);
        chk_state("pin_lockout_idle", ST_IDLE);
        Card_in = 1'b0;
        step(E_NONE);

        // PIN change, then old rejected and new accepted
        start_session(17'h04444, 17'h00321);
        pin_try(17'h00321);
        do_chgpin(17'h00999);
        finish_txn(1'b1, 1'b0);
        start_session(17'h04444, 17'h00321);
        pin_try(17'h00321);
        chk_state("old_pin_rejected", ST_PIN);
        pin_try(17'h00999);
        chk_state("new_pin_accepted", ST_MENU);
        do_balance();
        finish_txn(1'b0, 1'b0);

        // Timer abort while waiting for the cash counter
        start_session(17'h03333, 17'h00789);
        pin_try(17'h00789);
        opcode = 3'b011; deposit_amount = 19'd500; money_counting = 1'b0;
        step(E_NONE);
        step(E_NONE);
        chk_state("deposit_waits", ST_DEPOSIT);
        Timer = 1'b1;
        step(E_NONE);
        chk_state("timer_abort_idle", ST_IDLE);
        Timer = 1'b0; Card_in = 1'b0;
        step(E_NONE);
        chk_bal(2, 13000);

        // Deposits including an overflowing one
        start_session(17'h03333, 17'h00789);
        pin_try(17'h00789);
        do_deposit(500);
        finish_txn(1'b0, 1'b1);
        do_deposit(524287);
        finish_txn(1'b0, 1'b0);
        chk_bal(2, 13500);
        chk_store();

        // Reset mid-session restores the store
        start_session(17'h01111, 17'h00123);
        pin_try(17'h00123);
        opcode = 3'b000;
        reset = 1'b1;
        step(E_NONE);
        reset = 1'b0; Card_in = 1'b0;
        model_reset();
        chk_state("midsession_reset", ST_IDLE);
        chk_bal(0, 10000);
        step(E_NONE);
        chk_store();

        @(negedge clk);
        #1;
        rnd_mode = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            Card_in = ($urandom_range(0, 19) != 0);
            Timer = ($urandom_range(0, 49) == 0);
            Language = 1'($urandom);
            money_counting = 1'($urandom);
            another_transaction_bit = 1'($urandom);
            opcode = 3'($urandom);
            Pers_Account_No = acct_no(2'($urandom));
            password = ($urandom_range(0, 1) == 0) ? reset_pin(2'($urandom)) : 17'($urandom);
            new_pin = 17'($urandom);
            allowwithdraw = 1'($urandom);
            take_receipt = 1'($urandom);
            allow_transfer = 1'($urandom);
            ur_account = acct_no(2'($urandom));
            withdraw_amount = 19'($urandom_range(0, 20000));
            Transfer_Amount = 19'($urandom_range(0, 20000));
            deposit_amount = 19'($urandom);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
